// File: rtl/serial_pkg.sv
// Shared definitions for the serial packer/converter family: default word and
// symbol widths, the symbols-per-word helper and the fill/full state encoding.
package serial_pkg;

    localparam int DEFAULT_ROM_DATA_WIDTH = 96;
    localparam int DEFAULT_SELECT_SIZE    = 3;
    localparam int DEFAULT_ADDR_WIDTH     = 8;

    // S_FILL: assembling a word, symbols accepted.
    // S_FULL: a complete word waits behind an occupied output register.
    typedef enum logic [0:0] {
        S_FILL = 1'b0,
        S_FULL = 1'b1
    } pack_state_t;

    // Number of symbols that make up one packed word.
    function automatic int symbols_per_word(input int rom_width, input int select_size);
        return rom_width / select_size;
    endfunction

endpackage

// File: rtl/serial_data_packer_if.sv
// Bus between a symbol producer / word consumer (master) and the packer (slave).
//
// Handshake rules, both channels:
//   - A symbol transfers on a rising clk edge where data_valid_i && serial_ready_o.
//   - A word transfers on a rising clk edge where word_valid_o && word_ready_i;
//     word_o/word_addr_o hold steady while word_valid_o=1 and word_ready_i=0.
//   - frame_start_i is sampled on the same edge and takes priority over a word
//     transfer (the word is discarded, not delivered).
// state_o exposes the packer FSM state for observation.
interface serial_data_packer_if
    import serial_pkg::*;
#(
    parameter int ROM_DATA_WIDTH = DEFAULT_ROM_DATA_WIDTH,
    parameter int SELECT_SIZE    = DEFAULT_SELECT_SIZE,
    parameter int ADDR_WIDTH     = DEFAULT_ADDR_WIDTH
);

    logic                      frame_start_i;
    logic                      data_valid_i;
    logic [SELECT_SIZE-1:0]    serial_data_i;
    logic                      serial_ready_o;
    logic                      word_valid_o;
    logic                      word_ready_i;
    logic [ROM_DATA_WIDTH-1:0] word_o;
    logic [ADDR_WIDTH-1:0]     word_addr_o;
    logic                      overflow_o;
    pack_state_t               state_o;

    modport master (
        output frame_start_i, data_valid_i, serial_data_i, word_ready_i,
        input  serial_ready_o, word_valid_o, word_o, word_addr_o, overflow_o, state_o
    );

    modport slave (
        input  frame_start_i, data_valid_i, serial_data_i, word_ready_i,
        output serial_ready_o, word_valid_o, word_o, word_addr_o, overflow_o, state_o
    );

endinterface

// File: rtl/serial_data_packer.sv
// Serial symbol packer: gathers ROM_DATA_WIDTH/SELECT_SIZE symbols MSB-first
// into a word and presents it with an incrementing word address.
// Build option SERIAL_PACKER_DROP_EN: symbol input never stalls; symbols that
// arrive while a complete word is held are discarded and flagged on overflow_o.
// Without it the input is backpressured and overflow_o is constant 0.
// ROM_DATA_WIDTH must be a multiple of SELECT_SIZE and hold at least two symbols.
module serial_data_packer
    import serial_pkg::*;
#(
    parameter int ROM_DATA_WIDTH = DEFAULT_ROM_DATA_WIDTH,
    parameter int SELECT_SIZE    = DEFAULT_SELECT_SIZE,
    parameter int ADDR_WIDTH     = DEFAULT_ADDR_WIDTH
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    serial_data_packer_if.slave  bus
);

    localparam int N     = symbols_per_word(ROM_DATA_WIDTH, SELECT_SIZE);
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST_SYM = CNT_W'(N - 1);

    pack_state_t               r_state, w_state_nxt;
    logic [CNT_W-1:0]          r_cnt, w_cnt_nxt;
    logic [ROM_DATA_WIDTH-1:0] r_shift, w_shift_nxt, w_shift_in;
    logic [ROM_DATA_WIDTH-1:0] r_word, w_word_nxt;
    logic                      r_valid, w_valid_nxt;
    logic [ADDR_WIDTH-1:0]     r_addr, w_addr_nxt;
    logic                      w_ready;
    logic                      w_accept;
    logic                      w_handshake;
    logic                      w_out_free;

`ifdef SERIAL_PACKER_DROP_EN
    assign w_ready = 1'b1;
`else
    assign w_ready = (r_state == S_FILL);
`endif

    assign w_accept    = bus.data_valid_i && w_ready;
    assign w_handshake = r_valid && bus.word_ready_i;
    // The output register can take a new word if it is empty or being emptied now.
    assign w_out_free  = !r_valid || bus.word_ready_i;
    // Earlier symbols move up one slot; the new symbol enters the low slice.
    assign w_shift_in  = {r_shift[ROM_DATA_WIDTH-SELECT_SIZE-1:0], bus.serial_data_i};

    // Next-state and datapath update; frame start outranks everything else.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_shift_nxt = r_shift;
        w_word_nxt  = r_word;
        w_valid_nxt = r_valid;
        w_addr_nxt  = r_addr;
        if (bus.frame_start_i) begin
            w_state_nxt = S_FILL;
            w_valid_nxt = 1'b0;
            w_addr_nxt  = '0;
            if (w_accept) begin
                // This symbol opens the new frame as symbol 0.
                w_shift_nxt = {{(ROM_DATA_WIDTH-SELECT_SIZE){1'b0}}, bus.serial_data_i};
                w_cnt_nxt   = CNT_W'(1);
            end else begin
                w_shift_nxt = '0;
                w_cnt_nxt   = '0;
            end
        end else begin
            if (w_handshake) begin
                w_valid_nxt = 1'b0;
                w_addr_nxt  = r_addr + ADDR_WIDTH'(1);
            end
            case (r_state)
                S_FILL: begin
                    if (w_accept) begin
                        w_shift_nxt = w_shift_in;
                        if (r_cnt == LAST_SYM) begin
                            w_cnt_nxt = '0;
                            if (w_out_free) begin
                                w_word_nxt  = w_shift_in;
                                w_valid_nxt = 1'b1;
                            end else begin
                                w_state_nxt = S_FULL;
                            end
                        end else begin
                            w_cnt_nxt = r_cnt + CNT_W'(1);
                        end
                    end
                end
                S_FULL: begin
                    // Held word follows the departing one on the same edge.
                    if (w_handshake) begin
                        w_word_nxt  = r_shift;
                        w_valid_nxt = 1'b1;
                        w_state_nxt = S_FILL;
                    end
                end
                default: w_state_nxt = S_FILL;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath registers: symbol counter, shift register, output word and address.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt   <= '0;
            r_shift <= '0;
            r_word  <= '0;
            r_valid <= 1'b0;
            r_addr  <= '0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_shift <= w_shift_nxt;
            r_word  <= w_word_nxt;
            r_valid <= w_valid_nxt;
            r_addr  <= w_addr_nxt;
        end
    end

`ifdef SERIAL_PACKER_DROP_EN
    logic r_overflow;

    // Sticky drop flag: set by a symbol arriving while a full word is held.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_overflow <= 1'b0;
        end else if (bus.frame_start_i) begin
            r_overflow <= 1'b0;
        end else if (w_accept && (r_state == S_FULL)) begin
            r_overflow <= 1'b1;
        end
    end

    assign bus.overflow_o = r_overflow;
`else
    assign bus.overflow_o = 1'b0;
`endif

    assign bus.serial_ready_o = w_ready;
    assign bus.word_valid_o   = r_valid;
    assign bus.word_o         = r_word;
    assign bus.word_addr_o    = r_addr;
    assign bus.state_o        = r_state;

endmodule

// File: tb/tb_serial_data_packer.sv
// Bench for serial_data_packer: symbol driver tasks, a packing model that
// pushes expected words/addresses into queues, and a monitor that pops and
// compares on every word handshake.
module tb_serial_data_packer;
    import serial_pkg::*;

    localparam int W = 96;
    localparam int S = 3;
    localparam int A = 8;
    localparam int N = W / S;
    localparam logic [W-1:0] REF_WORD = 96'o01234567012345670123456701234567;

    logic clk;
    logic rst_n;

    serial_data_packer_if #(.ROM_DATA_WIDTH(W), .SELECT_SIZE(S), .ADDR_WIDTH(A)) bus ();

    serial_data_packer #(.ROM_DATA_WIDTH(W), .SELECT_SIZE(S), .ADDR_WIDTH(A)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    logic [A-1:0] exp_addr_q[$];
    logic [W-1:0] model_word;
    logic [A-1:0] model_addr;
    int           model_cnt;
    int           n_checks;
    int           n_errors;
    logic [W-1:0] mon_word;
    logic [A-1:0] mon_addr;

    task automatic check(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        exp_addr_q.delete();
        model_word = '0;
        model_addr = '0;
        model_cnt  = 0;
    endtask

    task automatic model_push(input logic [S-1:0] sym);
        model_word = {model_word[W-S-1:0], sym};
        model_cnt++;
        if (model_cnt == N) begin
            exp_q.push_back(model_word);
            exp_addr_q.push_back(model_addr);
            model_addr = model_addr + 1'b1;
            model_cnt  = 0;
        end
    endtask

    // Word handshake monitor (frame start cancels the transfer).
    always @(negedge clk) begin
        if (rst_n && !bus.frame_start_i && bus.word_valid_o && bus.word_ready_i) begin
            if (exp_q.size() == 0) begin
                check("unexpected_word", 1, 0);
            end else begin
                mon_word = exp_q.pop_front();
                mon_addr = exp_addr_q.pop_front();
                check("word", bus.word_o, mon_word);
                check("addr", W'(bus.word_addr_o), W'(mon_addr));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic to_drive();
        @(posedge clk);
        #1;
    endtask

    // Present one symbol, wait (bounded) for acceptance, return at edge+1.
    task automatic send_sym(input logic [S-1:0] sym);
        bit got;
        got = 1'b0;
        bus.data_valid_i  = 1'b1;
        bus.serial_data_i = sym;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus.serial_ready_o) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            check("ready_timeout", 0, 1);
        end else begin
            model_push(sym);
        end
        @(posedge clk);
        #1;
        bus.data_valid_i = 1'b0;
    endtask

    task automatic frame_start(input bit with_sym, input logic [S-1:0] sym);
        bus.frame_start_i = 1'b1;
        bus.data_valid_i  = with_sym;
        bus.serial_data_i = sym;
        @(negedge clk);
        model_clear();
        if (with_sym) begin
            check("fs_ready", W'(bus.serial_ready_o), 1);
            model_push(sym);
        end
        @(posedge clk);
        #1;
        bus.frame_start_i = 1'b0;
        bus.data_valid_i  = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        check("drain_left", W'(exp_q.size()), 0);
        @(negedge clk);
        check("idle_valid", W'(bus.word_valid_o), 0);
        to_drive();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        n_checks = 0;
        n_errors = 0;
        model_clear();
        rst_n             = 1'b0;
        bus.frame_start_i = 1'b0;
        bus.data_valid_i  = 1'b0;
        bus.serial_data_i = '0;
        bus.word_ready_i  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", W'(bus.word_valid_o), 0);
        check("rst_word", bus.word_o, 0);
        check("rst_addr", W'(bus.word_addr_o), 0);
        check("rst_ovf", W'(bus.overflow_o), 0);
        check("rst_state", W'(bus.state_o), W'(S_FILL));
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_ready", W'(bus.serial_ready_o), 1);
        to_drive();

        // One word of 0..7 repeating, consumer always ready.
        bus.word_ready_i = 1'b1;
        for (int i = 0; i < N; i++) send_sym(S'(i % 8));
        @(negedge clk);
        check("lat_valid", W'(bus.word_valid_o), 1);
        check("ref_word", bus.word_o, REF_WORD);
        @(negedge clk);
        check("pulse_end", W'(bus.word_valid_o), 0);
        to_drive();
        drain();

        // Backpressure: two words with the consumer stalled.
        frame_start(1'b0, '0);
        bus.word_ready_i = 1'b0;
        for (int i = 0; i < 2 * N; i++) send_sym(S'($urandom_range(0, 7)));
        @(negedge clk);
        check("bp_ready_low", W'(bus.serial_ready_o), 0);
        check("bp_state", W'(bus.state_o), W'(S_FULL));
        check("bp_word0", bus.word_o, exp_q[0]);
        check("bp_addr0", W'(bus.word_addr_o), 0);
        check("bp_ovf", W'(bus.overflow_o), 0);
        repeat (4) @(negedge clk);
        check("bp_hold_word", bus.word_o, exp_q[0]);
        check("bp_hold_valid", W'(bus.word_valid_o), 1);
        to_drive();
        bus.word_ready_i = 1'b1;
        drain();

        // Frame start with a word pending and a consumer handshake in the same cycle.
        bus.word_ready_i = 1'b0;
        for (int i = 0; i < N + 10; i++) send_sym(S'($urandom_range(0, 7)));
        bus.word_ready_i = 1'b1;
        frame_start(1'b0, '0);
        @(negedge clk);
        check("fs_valid_drop", W'(bus.word_valid_o), 0);
        check("fs_addr", W'(bus.word_addr_o), 0);
        to_drive();
        for (int i = 0; i < N; i++) send_sym(S'($urandom_range(0, 7)));
        drain();

        // Symbol accepted together with frame start opens the new word.
        for (int i = 0; i < 5; i++) send_sym(S'($urandom_range(0, 7)));
        frame_start(1'b1, 3'd5);
        for (int i = 1; i < N; i++) send_sym(S'($urandom_range(0, 7)));
        drain();

        // Address wrap: 257 words after a fresh frame.
        frame_start(1'b0, '0);
        for (int w = 0; w < 257; w++)
            for (int i = 0; i < N; i++) send_sym(S'($urandom_range(0, 7)));
        drain();

        // Asynchronous reset mid-word with a word pending.
        bus.word_ready_i = 1'b0;
        for (int i = 0; i < N + 17; i++) send_sym(S'($urandom_range(0, 7)));
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_valid", W'(bus.word_valid_o), 0);
        check("arst_word", bus.word_o, 0);
        check("arst_addr", W'(bus.word_addr_o), 0);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("arst_ready", W'(bus.serial_ready_o), 1);
        to_drive();
        bus.word_ready_i = 1'b1;
        for (int i = 0; i < N; i++) send_sym(S'(i % 8));
        @(negedge clk);
        check("arst_clean_word", bus.word_o, REF_WORD);
        to_drive();
        drain();

`ifdef SERIAL_PACKER_DROP_EN
        // Drop mode: 70 symbols against a stalled consumer.
        frame_start(1'b0, '0);
        bus.word_ready_i = 1'b0;
        for (int i = 0; i < 70; i++) begin
            bus.data_valid_i  = 1'b1;
            bus.serial_data_i = S'(i % 8);
            @(negedge clk);
            check("drop_ready", W'(bus.serial_ready_o), 1);
            check("drop_ovf", W'(bus.overflow_o), W'(i >= 65));
            if (i < 2 * N) model_push(S'(i % 8));
            @(posedge clk);
            #1;
        end
        bus.data_valid_i = 1'b0;
        @(negedge clk);
        check("drop_word0", bus.word_o, REF_WORD);
        check("drop_ovf_end", W'(bus.overflow_o), 1);
        to_drive();
        bus.word_ready_i = 1'b1;
        drain();
        frame_start(1'b0, '0);
        @(negedge clk);
        check("drop_ovf_clr", W'(bus.overflow_o), 0);
        to_drive();
`endif

        check("final_queue", W'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Global watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/serial_data_packer.md
SERIAL_DATA_PACKER -- requirements
Module: serial_data_packer

Interface
REQ-001 SHALL have parameter ROM_DATA_WIDTH, default 96: packed word width in bits.
REQ-002 SHALL have parameter SELECT_SIZE, default 3: symbol width in bits; ROM_DATA_WIDTH SHALL be an integer multiple of it.
REQ-003 SHALL have parameter ADDR_WIDTH, default 8: word address width.
REQ-004 SHALL have one clock and an asynchronous, active-low reset: clk_i input 1, rising-edge clock; rst_ni input 1, async active-low reset.
REQ-005 frame_start_i  input  1  restart packing at word 0, address 0.
REQ-006 data_valid_i  input  1  serial_data_i carries a symbol.
REQ-007 serial_data_i  input  SELECT_SIZE  incoming symbol.
REQ-008 serial_ready_o  output  1  block can accept a symbol this cycle.
REQ-009 word_valid_o  output  1  word_o/word_addr_o valid.
REQ-010 word_ready_i  input  1  consumer takes the word.
REQ-011 word_o  output  ROM_DATA_WIDTH  packed word.
REQ-012 word_addr_o  output  ADDR_WIDTH  destination word address.
REQ-013 overflow_o  output  1  sticky symbol-drop flag.

Function
REQ-014 N = ROM_DATA_WIDTH/SELECT_SIZE symbols per word; symbol counter width $clog2(N).
REQ-015 Symbol accepted when data_valid_i && serial_ready_o; first accepted symbol of a word lands in word bits [ROM_DATA_WIDTH-1 -: SELECT_SIZE] (MSB-first), k-th in the next lower slice.
REQ-016 States: S_FILL (assembling, serial_ready_o=1), S_FULL (shift register complete, output register occupied, serial_ready_o=0).
REQ-017 On the Nth acceptance: if output register empty or handshaking this cycle, word moves to word_o, word_valid_o=1 next cycle (latency 1), counter->0, stay S_FILL; else go S_FULL.
REQ-018 S_FULL -> S_FILL on word_valid_o && word_ready_i; held word moves to word_o in that same edge.
REQ-019 word_o, word_addr_o stable while word_valid_o=1 and word_ready_i=0.
REQ-020 word_addr_o increments by 1 on each word handshake; wraps 2^ADDR_WIDTH-1 -> 0.
REQ-021 frame_start_i: discards partial word, held word and pending output (word_valid_o->0), counter and address->0, state->S_FILL; a symbol accepted in the same cycle becomes symbol 0 of the new frame.
REQ-022 frame_start_i overrides simultaneous word handshake (no address increment).
REQ-023 Steady-state throughput: one symbol per cycle with word_ready_i held 1.

Reset
REQ-024 rst_ni low asynchronously forces: state S_FILL, counter 0, word_addr_o 0, word_o 0, word_valid_o 0, overflow_o 0, shift register 0; serial_ready_o 1 after release.
REQ-025 Reset mid-word or mid-handshake SHALL lose all data without glitching outputs beyond the async clear.

Configuration
REQ-026 Macro SERIAL_PACKER_DROP_EN: defined -> serial_ready_o tied 1; symbols arriving in S_FULL are discarded and overflow_o set (cleared only by reset or frame_start_i).
REQ-027 Undefined -> serial_ready_o per REQ-016 (backpressure), overflow_o constant 0.

Structure
REQ-028 Shared package serial_pkg SHALL hold ROM_DATA_WIDTH/SELECT_SIZE defaults, symbols-per-word function, and state encoding shared with serial_data_converter.
REQ-029 Single module; no sub-module required.

Verification
REQ-030 Reset release, 32 symbols 0..7 repeating, word_ready_i=1 -> one word_valid_o pulse, word_o = 96'o01234567012345670123456701234567, addr 0, 1 cycle after symbol 32.
REQ-031 word_ready_i=0, 64 symbols back-to-back -> first word held at addr 0, serial_ready_o low after symbol 64; raise word_ready_i -> words at addr 0 then 1, no loss.
REQ-032 frame_start_i after 10 symbols with valid word pending -> word_valid_o drops, next 32 symbols form word at addr 0.
REQ-033 256 words streamed (ADDR_WIDTH=8) -> word 257 at addr 0.
REQ-034 SERIAL_PACKER_DROP_EN defined, word_ready_i=0, 70 symbols -> overflow_o=1 from symbol 65, first word unchanged.
REQ-035 rst_ni pulsed low mid-word (symbol 17) -> all outputs 0 immediately; next 32 symbols yield a clean word at addr 0.
